data_bus_arbiter: RTL
=====================

Name: data_bus_arbiter

Overview:
- Shares the single data memory bus between two requesters: port 0 (core load/store unit, `core_*`) and port 1 (DMA/debug master, `dma_*`).
- Sits between the requesters and the data memory bus, upstream of the memory slave.
- Sequences one outstanding transaction at a time through a req/gnt/rvalid handshake.
- Arbitrates round-robin between the two ports.

Parameters:
- TIMEOUT_CYCLES, 256: cycles a transaction may spend in REQ+RESP before abort. Used only with the optional feature. Legal range 2..65535.

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core requests a transaction; held with fields stable until core_gnt
- core_write_enable  in  1  1 = write, 0 = read
- core_address  in  32  byte address
- core_write_data  in  32  write data, already lane-shifted
- core_byte_enable  in  4  lane enables
- core_gnt  out  1  one-cycle pulse: core's request accepted by memory
- core_rvalid  out  1  one-cycle pulse: core's transaction complete
- core_read_data  out  32  read data; valid when core_rvalid
- core_err  out  1  qualifies core_rvalid: transaction aborted
- dma_req, dma_write_enable, dma_address, dma_write_data, dma_byte_enable  in  1/1/32/32/4  same as core_*
- dma_gnt, dma_rvalid, dma_read_data, dma_err  out  1/1/32/1  same as core_*
- bus_req  out  1  request to memory
- bus_write_enable  out  1  latched write flag
- bus_address  out  32  latched address
- bus_write_data  out  32  latched write data
- bus_byte_enable  out  4  latched byte enables
- bus_gnt  in  1  memory accepts request this cycle
- bus_rvalid  in  1  memory returns response (reads and writes)
- bus_read_data  in  32  memory read data

Behaviour:
- Reset (async): state=IDLE, owner=0, last_owner=1 (core wins first tie), timeout counter=0. All outputs 0, including bus fields and *_read_data.
- IDLE: if any req is high, select the owner:
  - only one port requesting: that port;
  - both requesting: the port != last_owner.
  - Latch the owner's write_enable, address, write_data and byte_enable into the bus_* registers; set last_owner=owner; go to REQ.
  - No req: stay in IDLE, bus_req=0.
- REQ:
  - bus_req=1; bus_* fields stable for the whole state.
  - owner_gnt = bus_gnt (combinational pass-through to the owner only); non-owner gnt=0.
  - On bus_gnt=1: go to RESP, bus_req=0 from the next cycle.
  - bus_rvalid in REQ is ignored.
- RESP:
  - bus_req=0.
  - On bus_rvalid=1: register bus_read_data into owner_read_data; owner_rvalid=1 in the following cycle only; go to IDLE.
- *_read_data holds its value until the next response to that port. A write response also updates it with bus_read_data; its contents are don't-care.
- Minimum latency, req at cycle 0:
  - bus_req at cycle 1;
  - gnt at cycle 1 if bus_gnt=1;
  - bus_rvalid earliest at cycle 2;
  - owner rvalid at cycle 3;
  - next arbitration at cycle 3.
- Non-owner req is held pending; it is never dropped or lost.
- Owner deasserting req after selection is illegal. The latched transaction completes regardless.
- Fields at the requester are sampled only in IDLE. Later changes do not affect bus_* outputs.
- Reset mid-transaction: immediate return to IDLE, bus_req=0, no rvalid is issued. A memory response arriving later in IDLE is ignored.
- At most one of core_rvalid/dma_rvalid is high in any cycle; likewise for gnt.

Optional Feature:
- Macro DATA_BUS_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter is cleared on entry to REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES without completion: drop bus_req, and return IDLE at the next edge.
  - Owner gets rvalid=1, err=1, read_data=0 in the following cycle; no gnt pulse if aborted in REQ.
  - A completion in the same cycle as the timeout takes priority: normal response, err=0.
- Undefined: no counter; *_err tied to 0; transactions wait indefinitely.

Test Plan:
- Core read to 0x0000_1004, bus_gnt immediate, bus_rvalid one cycle later with 0xDEADBEEF -> bus_address=0x0000_1004 at cycle 1, core_gnt cycle 1, core_rvalid=1 at cycle 3 with core_read_data=0xDEADBEEF, dma outputs stay 0.
- core_req and dma_req held high together for 4 transactions -> grant order core, dma, core, dma; never two gnt pulses in one cycle.
- DMA write 0x1122_3344 to 0x20, byte_enable 4'b1111, bus_gnt low 5 cycles -> bus_req high 5+ cycles with fields constant; dma_gnt single pulse; dma_rvalid, dma_err=0.
- Reset asserted in RESP, memory returns bus_rvalid after reset release -> no rvalid on either port; all outputs 0 during reset; next core_req served normally.
- With DATA_BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_gnt never asserted -> after 8 cycles bus_req drops, core_rvalid=1, core_err=1, core_read_data=0, no core_gnt.
- Same stimulus without macro -> bus_req held indefinitely (checked 1000 cycles), core_err never 1.

Source files
------------

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// data_bus_arbiter: round-robin sharing of one data memory bus between core (port 0) and DMA (port 1).
// Optional transaction abort after TIMEOUT_CYCLES is enabled by defining DATA_BUS_ARB_TIMEOUT_EN.
module data_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_write_enable,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [3:0]  core_byte_enable,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_read_data,
  output logic        core_err,
  input  logic        dma_req,
  input  logic        dma_write_enable,
  input  logic [31:0] dma_address,
  input  logic [31:0] dma_write_data,
  input  logic [3:0]  dma_byte_enable,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_read_data,
  output logic        dma_err,
  output logic        bus_req,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;
  logic   owner;       // 0 = core, 1 = dma
  logic   last_owner;
  logic   any_req;
  logic   sel;
  logic   complete;
  logic   timeout;
  logic   abort;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("data_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  assign any_req  = core_req | dma_req;
  // A tie goes to whichever port did not win the previous arbitration.
  assign sel      = (core_req & dma_req) ? ~last_owner : dma_req;
  assign complete = (state == RESP) & bus_rvalid;

`ifdef DATA_BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] timeout_count;
  logic        core_err_q;
  logic        dma_err_q;

  assign timeout = (state != IDLE) && (timeout_count == TIMEOUT_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_count <= '0;
    end else if (state == IDLE) begin
      timeout_count <= '0;
    end else begin
      timeout_count <= timeout_count + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      core_err_q <= 1'b0;
      dma_err_q  <= 1'b0;
    end else begin
      core_err_q <= abort & ~owner;
      dma_err_q  <= abort & owner;
    end
  end

  assign core_err = core_err_q;
  assign dma_err  = dma_err_q;
`else
  assign timeout  = 1'b0;
  assign core_err = 1'b0;
  assign dma_err  = 1'b0;
`endif

  // A response landing in the timeout cycle wins over the abort.
  assign abort = timeout & ~complete;

  always_comb begin
    state_next = state;
    bus_req    = 1'b0;
    core_gnt   = 1'b0;
    dma_gnt    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = REQ;
      end
      REQ: begin
        if (timeout) begin
          state_next = IDLE;
        end else begin
          bus_req  = 1'b1;
          core_gnt = bus_gnt & ~owner;
          dma_gnt  = bus_gnt & owner;
          if (bus_gnt) state_next = RESP;
        end
      end
      RESP: begin
        if (bus_rvalid || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last_owner       <= 1'b1;
      bus_write_enable <= 1'b0;
      bus_address      <= '0;
      bus_write_data   <= '0;
      bus_byte_enable  <= '0;
      core_rvalid      <= 1'b0;
      dma_rvalid       <= 1'b0;
      core_read_data   <= '0;
      dma_read_data    <= '0;
    end else begin
      state       <= state_next;
      core_rvalid <= 1'b0;
      dma_rvalid  <= 1'b0;
      if (state == IDLE && any_req) begin
        owner            <= sel;
        last_owner       <= sel;
        bus_write_enable <= sel ? dma_write_enable : core_write_enable;
        bus_address      <= sel ? dma_address      : core_address;
        bus_write_data   <= sel ? dma_write_data   : core_write_data;
        bus_byte_enable  <= sel ? dma_byte_enable  : core_byte_enable;
      end
      if (complete || abort) begin
        if (owner) begin
          dma_rvalid    <= 1'b1;
          dma_read_data <= complete ? bus_read_data : 32'h0;
        end else begin
          core_rvalid    <= 1'b1;
          core_read_data <= complete ? bus_read_data : 32'h0;
        end
      end
    end
  end

endmodule
`default_nettype wire
